// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the miniLA ID/EX stage: ALU opcodes,
// register-index width, the zero register, and a reference ALU evaluation.
package id_ex_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int REG_ZERO  = 0;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_AND    = 4'h2,
        OP_OR     = 4'h3,
        OP_XOR    = 4'h4,
        OP_SLL    = 4'h5,
        OP_SRL    = 4'h6,
        OP_SRA    = 4'h7,
        OP_SLT    = 4'h8,
        OP_SLTU   = 4'h9,
        OP_LU12I  = 4'hA,
        OP_PCADDU = 4'hB
    } alu_op_e;

    // B carries the first operand (rj or PC); A carries the second operand
    // (rk/rd or immediate), which is also the shift amount.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        res = '0;
        case (op)
            OP_ADD:    res = b + a;
            OP_SUB:    res = b - a;
            OP_AND:    res = b & a;
            OP_OR:     res = b | a;
            OP_XOR:    res = b ^ a;
            OP_SLL:    res = b << a[4:0];
            OP_SRL:    res = b >> a[4:0];
            OP_SRA:    res = $unsigned($signed(b) >>> a[4:0]);
            OP_SLT:    res = {{(DATA_W-1){1'b0}}, $signed(b) < $signed(a)};
            OP_SLTU:   res = {{(DATA_W-1){1'b0}}, b < a};
            OP_LU12I:  res = a << 12;
            OP_PCADDU: res = b + (a << 12);
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID/EX stage and its surroundings: decoded ID
// fields, hazard control, MEM/WB forwarding sources and the EX-side outputs.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [RW-1:0] id_rj_idx;
    logic [RW-1:0] id_rk_idx;
    logic [DW-1:0] id_rj_data;
    logic [DW-1:0] id_rk_data;
    logic [DW-1:0] id_imm;
    logic          id_b_sel_pc;
    logic          id_a_sel_imm;
    logic [3:0]    id_alu_op;
    logic [RW-1:0] id_rd_idx;
    logic          id_wr_en;

    logic          stall;
    logic          flush;

    logic          mem_wr_en;
    logic [RW-1:0] mem_rd_idx;
    logic [DW-1:0] mem_fwd_data;
    logic          wb_wr_en;
    logic [RW-1:0] wb_rd_idx;
    logic [DW-1:0] wb_fwd_data;

    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [RW-1:0] ex_rd_idx;
    logic          ex_wr_en;
    logic [DW-1:0] ex_rk_fwd;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;

    modport master (
        output id_valid, id_pc, id_rj_idx, id_rk_idx, id_rj_data, id_rk_data,
               id_imm, id_b_sel_pc, id_a_sel_imm, id_alu_op, id_rd_idx, id_wr_en,
               stall, flush,
               mem_wr_en, mem_rd_idx, mem_fwd_data, wb_wr_en, wb_rd_idx, wb_fwd_data,
        input  ex_valid, ex_pc, ex_rd_idx, ex_wr_en, ex_rk_fwd, alu_a, alu_b, alu_op
    );

    modport slave (
        input  id_valid, id_pc, id_rj_idx, id_rk_idx, id_rj_data, id_rk_data,
               id_imm, id_b_sel_pc, id_a_sel_imm, id_alu_op, id_rd_idx, id_wr_en,
               stall, flush,
               mem_wr_en, mem_rd_idx, mem_fwd_data, wb_wr_en, wb_rd_idx, wb_fwd_data,
        output ex_valid, ex_pc, ex_rd_idx, ex_wr_en, ex_rk_fwd, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register index: MEM result beats WB
// result, which beats the stored regfile value; r0 never forwards.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_idx,
    input  logic [DW-1:0] i_reg_data,
    input  logic          i_mem_wr_en,
    input  logic [RW-1:0] i_mem_rd_idx,
    input  logic [DW-1:0] i_mem_data,
    input  logic          i_wb_wr_en,
    input  logic [RW-1:0] i_wb_rd_idx,
    input  logic [DW-1:0] i_wb_data,
    output logic [DW-1:0] o_data
);

    logic w_nonzero;

    assign w_nonzero = (i_idx != RW'(REG_ZERO));

    always_comb begin
        o_data = i_reg_data;
        if (w_nonzero && i_mem_wr_en && (i_mem_rd_idx == i_idx)) begin
            o_data = i_mem_data;
        end else if (w_nonzero && i_wb_wr_en && (i_wb_rd_idx == i_idx)) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the miniLA core: latches decoded instructions,
// applies stall/flush, and drives forwarded ALU operands to the execute stage.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int RW = REG_IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_stage_if.slave bus
);

    logic          r_valid;
    logic [DW-1:0] r_pc;
    logic [RW-1:0] r_rj_idx;
    logic [RW-1:0] r_rk_idx;
    logic [DW-1:0] r_rj_data;
    logic [DW-1:0] r_rk_data;
    logic [DW-1:0] r_imm;
    logic          r_b_sel_pc;
    logic          r_a_sel_imm;
    logic [3:0]    r_alu_op;
    logic [RW-1:0] r_rd_idx;
    logic          r_wr_en;

    logic [DW-1:0] w_fwd_rj;
    logic [DW-1:0] w_fwd_rk;

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rj (
        .i_idx        (r_rj_idx),
        .i_reg_data   (r_rj_data),
        .i_mem_wr_en  (bus.mem_wr_en),
        .i_mem_rd_idx (bus.mem_rd_idx),
        .i_mem_data   (bus.mem_fwd_data),
        .i_wb_wr_en   (bus.wb_wr_en),
        .i_wb_rd_idx  (bus.wb_rd_idx),
        .i_wb_data    (bus.wb_fwd_data),
        .o_data       (w_fwd_rj)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rk (
        .i_idx        (r_rk_idx),
        .i_reg_data   (r_rk_data),
        .i_mem_wr_en  (bus.mem_wr_en),
        .i_mem_rd_idx (bus.mem_rd_idx),
        .i_mem_data   (bus.mem_fwd_data),
        .i_wb_wr_en   (bus.wb_wr_en),
        .i_wb_rd_idx  (bus.wb_rd_idx),
        .i_wb_data    (bus.wb_fwd_data),
        .o_data       (w_fwd_rk)
    );

    // A stall re-captures the forwarded operands so a producer retiring from
    // WB while EX is held is not lost once it leaves the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rj_idx    <= '0;
            r_rk_idx    <= '0;
            r_rj_data   <= '0;
            r_rk_data   <= '0;
            r_imm       <= '0;
            r_b_sel_pc  <= 1'b0;
            r_a_sel_imm <= 1'b0;
            r_alu_op    <= '0;
            r_rd_idx    <= '0;
            r_wr_en     <= 1'b0;
        end else if (!bus.stall) begin
            r_valid     <= bus.id_valid;
            r_pc        <= bus.id_pc;
            r_rj_idx    <= bus.id_rj_idx;
            r_rk_idx    <= bus.id_rk_idx;
            r_rj_data   <= bus.id_rj_data;
            r_rk_data   <= bus.id_rk_data;
            r_imm       <= bus.id_imm;
            r_b_sel_pc  <= bus.id_b_sel_pc;
            r_a_sel_imm <= bus.id_a_sel_imm;
            r_alu_op    <= bus.id_alu_op;
            r_rd_idx    <= bus.id_rd_idx;
            r_wr_en     <= bus.id_wr_en & bus.id_valid;
        end else begin
            r_rj_data   <= w_fwd_rj;
            r_rk_data   <= w_fwd_rk;
        end
    end

    assign bus.ex_valid  = r_valid;
    assign bus.ex_pc     = r_pc;
    assign bus.ex_rd_idx = r_rd_idx;
    assign bus.ex_wr_en  = r_wr_en;
    assign bus.ex_rk_fwd = w_fwd_rk;
    assign bus.alu_b     = r_b_sel_pc ? r_pc : w_fwd_rj;
    assign bus.alu_a     = r_a_sel_imm ? r_imm : w_fwd_rk;
    assign bus.alu_op    = r_alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, load, forwarding
// priority, zero register, stall refresh, flush-over-stall and operand select.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_load(input logic [31:0] pc, input logic [4:0] rj, input logic [31:0] rjd,
                           input logic [4:0] rk, input logic [31:0] rkd, input logic [31:0] imm,
                           input logic bpc, input logic aimm, input logic [3:0] op,
                           input logic [4:0] rd, input logic wr, input logic vld);
        bus.id_pc        = pc;
        bus.id_rj_idx    = rj;
        bus.id_rj_data   = rjd;
        bus.id_rk_idx    = rk;
        bus.id_rk_data   = rkd;
        bus.id_imm       = imm;
        bus.id_b_sel_pc  = bpc;
        bus.id_a_sel_imm = aimm;
        bus.id_alu_op    = op;
        bus.id_rd_idx    = rd;
        bus.id_wr_en     = wr;
        bus.id_valid     = vld;
    endtask

    task automatic set_mem(input logic en, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_wr_en    = en;
        bus.mem_rd_idx   = rd;
        bus.mem_fwd_data = d;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_wr_en    = en;
        bus.wb_rd_idx   = rd;
        bus.wb_fwd_data = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);
        // Busy ID inputs during reset must not leak through
        id_load(32'hDEAD_0000, 5'd1, 32'h1111, 5'd2, 32'h2222, 32'h3333,
                1'b0, 1'b0, OP_SUB, 5'd3, 1'b1, 1'b1);
        tick();
        tick();
        check("rst_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("rst_ex_wr_en", {31'b0, bus.ex_wr_en}, 32'h0);
        check("rst_alu_op",   {28'b0, bus.alu_op},   32'h0);
        check("rst_alu_a",    bus.alu_a,             32'h0);
        check("rst_alu_b",    bus.alu_b,             32'h0);

        // ADD r4 = r1 + r2, no forwarding
        rst_n = 1'b1;
        id_load(32'h1C00_0010, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0,
                1'b0, 1'b0, OP_ADD, 5'd4, 1'b1, 1'b1);
        tick();
        check("add_alu_b",    bus.alu_b,             32'd5);
        check("add_alu_a",    bus.alu_a,             32'd7);
        check("add_ex_valid", {31'b0, bus.ex_valid}, 32'h1);
        check("add_ex_wr_en", {31'b0, bus.ex_wr_en}, 32'h1);
        check("add_alu_op",   {28'b0, bus.alu_op},   {28'b0, OP_ADD});
        check("add_ex_pc",    bus.ex_pc,             32'h1C00_0010);
        check("add_rd_idx",   {27'b0, bus.ex_rd_idx}, 32'd4);

        // MEM beats WB on the same rj
        id_load(32'h1C00_0014, 5'd3, 32'h99, 5'd5, 32'h55, 32'h0,
                1'b0, 1'b0, OP_SUB, 5'd6, 1'b1, 1'b1);
        tick();
        set_mem(1'b1, 5'd3, 32'h11);
        set_wb(1'b1, 5'd3, 32'h22);
        #1;
        check("fwd_mem_prio", bus.alu_b,     32'h11);
        check("fwd_rk_none",  bus.alu_a,     32'h55);
        check("fwd_rk_store", bus.ex_rk_fwd, 32'h55);
        set_mem(1'b0, 5'd3, 32'h11);
        #1;
        check("fwd_wb_only",  bus.alu_b,     32'h22);
        set_wb(1'b0, 5'd3, 32'h22);
        #1;
        check("fwd_stored",   bus.alu_b,     32'h99);

        // r0 is never forwarded
        id_load(32'h1C00_0018, 5'd6, 32'hA, 5'd0, 32'h0, 32'h0,
                1'b0, 1'b0, OP_OR, 5'd7, 1'b1, 1'b1);
        tick();
        set_mem(1'b1, 5'd0, 32'hFF);
        set_wb(1'b1, 5'd0, 32'hEE);
        #1;
        check("r0_alu_a",  bus.alu_a,     32'h0);
        check("r0_rk_fwd", bus.ex_rk_fwd, 32'h0);
        check("r0_alu_b",  bus.alu_b,     32'hA);
        set_mem(1'b0, 5'd0, 32'h0);
        set_wb(1'b0, 5'd0, 32'h0);

        // Stall two cycles; WB retires r7=0x33 during the first one only
        id_load(32'h1C00_001C, 5'd7, 32'h01, 5'd8, 32'h02, 32'h0,
                1'b0, 1'b0, OP_OR, 5'd9, 1'b1, 1'b1);
        tick();
        bus.stall = 1'b1;
        set_wb(1'b1, 5'd7, 32'h33);
        id_load(32'h0000_0200, 5'd10, 32'h5, 5'd11, 32'h6, 32'h0,
                1'b0, 1'b0, OP_XOR, 5'd13, 1'b1, 1'b1);
        tick();
        set_wb(1'b1, 5'd12, 32'h44);
        #1;
        check("stall1_alu_b", bus.alu_b, 32'h33);
        tick();
        check("stall2_alu_b", bus.alu_b, 32'h33);
        bus.stall = 1'b0;
        #1;
        check("rel_alu_b",   bus.alu_b,              32'h33);
        check("rel_alu_a",   bus.alu_a,              32'h02);
        check("rel_ex_pc",   bus.ex_pc,              32'h1C00_001C);
        check("rel_alu_op",  {28'b0, bus.alu_op},    {28'b0, OP_OR});
        check("rel_rd_idx",  {27'b0, bus.ex_rd_idx}, 32'd9);
        tick();
        check("next_ex_pc",  bus.ex_pc,              32'h0000_0200);
        check("next_alu_b",  bus.alu_b,              32'h5);

        // Flush and stall together: flush wins
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        check("flush_ex_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("flush_ex_wr_en", {31'b0, bus.ex_wr_en}, 32'h0);
        check("flush_ex_pc",    bus.ex_pc,             32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        id_load(32'h0000_0204, 5'd10, 32'h7, 5'd11, 32'h8, 32'h0,
                1'b0, 1'b0, OP_ADD, 5'd14, 1'b1, 1'b1);
        tick();
        check("post_flush_valid", {31'b0, bus.ex_valid}, 32'h1);
        check("post_flush_alu_b", bus.alu_b,             32'h7);

        // Bubble: write enable suppressed, operands still presented
        id_load(32'h0000_0208, 5'd10, 32'h9, 5'd11, 32'hB, 32'h0,
                1'b0, 1'b0, OP_ADD, 5'd15, 1'b1, 1'b0);
        tick();
        check("bubble_valid", {31'b0, bus.ex_valid}, 32'h0);
        check("bubble_wr_en", {31'b0, bus.ex_wr_en}, 32'h0);
        check("bubble_alu_a", bus.alu_a,             32'hB);
        set_wb(1'b0, 5'd0, 32'h0);

        // PCADDU: PC and immediate override forwarded register operands
        id_load(32'h1C00_0000, 5'd14, 32'h1, 5'd15, 32'h2, 32'h1,
                1'b1, 1'b1, OP_PCADDU, 5'd16, 1'b1, 1'b1);
        tick();
        set_mem(1'b1, 5'd15, 32'h77);
        #1;
        check("pcaddu_alu_b",  bus.alu_b,     32'h1C00_0000);
        check("pcaddu_alu_a",  bus.alu_a,     32'h1);
        check("pcaddu_rk_fwd", bus.ex_rk_fwd, 32'h77);
        check("pcaddu_result", alu_eval(bus.alu_op, bus.alu_a, bus.alu_b), 32'h1C00_1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage miniLA core, directly upstream of the execute-stage ALU.
- Latches decoded instructions from ID and drives the ALU operands `alu_a`/`alu_b`/`alu_op`.
- Resolves RAW hazards with MEM→EX and WB→EX forwarding, and applies stall and flush control.
- Operand convention, fixed: `alu_b` carries the first operand (rj or PC); `alu_a` carries the second operand (rk/rd or immediate, also the shift amount).

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_pc  in  DW  instruction PC
- id_rj_idx  in  RW  first source register index
- id_rk_idx  in  RW  second source index (rk or rd)
- id_rj_data  in  DW  regfile read data, port 1
- id_rk_data  in  DW  regfile read data, port 2
- id_imm  in  DW  extended immediate
- id_b_sel_pc  in  1  1 = B operand is PC
- id_a_sel_imm  in  1  1 = A operand is immediate
- id_alu_op  in  4  ALU opcode
- id_rd_idx  in  RW  destination index
- id_wr_en  in  1  writes destination
- stall  in  1  hold EX contents (hazard unit)
- flush  in  1  squash EX contents (branch taken)
- mem_wr_en  in  1  MEM-stage instruction writes
- mem_rd_idx  in  RW  MEM destination
- mem_fwd_data  in  DW  MEM-stage result
- wb_wr_en  in  1  WB-stage writes
- wb_rd_idx  in  RW  WB destination
- wb_fwd_data  in  DW  WB data
- ex_valid  out  1  EX holds a valid instruction
- ex_pc  out  DW  registered PC
- ex_rd_idx  out  RW  registered destination index
- ex_wr_en  out  1  registered write enable, gated by `ex_valid`
- ex_rk_fwd  out  DW  forwarded rk/rd value (store data, branch compare)
- alu_a  out  DW  ALU A operand
- alu_b  out  DW  ALU B operand
- alu_op  out  4  ALU opcode

Behaviour:
- Reset: on a rising edge of `clk` with `rst_n`=0, all registers clear. `ex_valid`=0, `ex_wr_en`=0, `alu_op`=4'h0, all data registers = 0. Reset overrides stall and flush.
- Register update, at each edge with `rst_n`=1, in priority order:
  - flush=1: `ex_valid`←0, `ex_wr_en`←0. Data fields don't-care but must be deterministic; clear them to 0.
  - else stall=0: load all ID fields; `ex_valid`←`id_valid`; `ex_wr_en`←`id_wr_en`&`id_valid`.
  - else (stall=1): keep the instruction, but refresh the stored rj/rk data with the current forwarded values. A WB producer that retires during the stall must not be lost.
- Flush beats stall when both are asserted.
- Forwarding, combinational from the registered fields:
  - `fwd_rj` = `mem_fwd_data` if `mem_wr_en` && `mem_rd_idx`==rj && rj≠0.
  - else `wb_fwd_data` if `wb_wr_en` && `wb_rd_idx`==rj && rj≠0.
  - else the stored rj data.
  - `fwd_rk` is identical with rk. MEM has priority over WB. Index 0 never forwards.
- Operand muxes:
  - `alu_b` = b_sel_pc ? pc : `fwd_rj`.
  - `alu_a` = a_sel_imm ? imm : `fwd_rk`.
  - `ex_rk_fwd` = `fwd_rk` always.
- Latency: an instruction presented by ID at edge N appears on the EX outputs after edge N (one cycle).
- Bubbles (`ex_valid`=0) still present registered operands. Downstream must gate its side effects on `ex_valid`; this block forces `ex_wr_en`=0 for bubbles.
- Outputs are the forwarding muxes only; there is no combinational path from ID inputs to outputs.

Decomposition:
- Shared package (`defines_pipeline.vh`): `OP_*` ALU opcodes, register-index width, `REG_ZERO` constant.
- One sub-module, `fwd_mux`: operand forwarding for a single source index. Instantiate it twice (rj, rk) and reuse it for the store-data path.

Test Plan:
- Reset and load:
  - rst_n=0 for 2 cycles → `ex_valid`=0, `alu_op`=0, `alu_a`=`alu_b`=0.
  - Then ADD with rj data 5, rk data 7, no forwarding → next cycle `alu_b`=5, `alu_a`=7, `ex_valid`=1.
- MEM forwarding priority:
  - EX rj=r3; MEM writes r3=0x11; WB writes r3=0x22 → `alu_b`=0x11.
  - MEM disabled → `alu_b`=0x22.
- Zero register: rk=r0, MEM writes r0=0xFF with wr_en=1 → `alu_a`=stored 0.
- Stall refresh:
  - Stall 2 cycles while WB writes rj=0x33 in the first stall cycle, after which WB moves on.
  - After release, `alu_b` still =0x33 and the instruction is unchanged.
- Flush vs stall:
  - stall=1 and flush=1 on the same edge → `ex_valid`=0, `ex_wr_en`=0.
  - Next ID instruction loads normally once both are deasserted.
- Operand select: PCADDU with pc=0x1C000000, imm=0x1, b_sel_pc=1, a_sel_imm=1 → `alu_b`=0x1C000000, `alu_a`=0x1, and the ALU yields 0x1C001000.
